// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial frame transmitter
// Contents: frame state enum, parity-mode constants, frame length helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Total clk cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_len(input int clks_per_bit, input int data_w,
                                     input int parity, input int stop_bits);
        return clks_per_bit * (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/serial_frame_tx_baud.sv
// rtl/serial_frame_tx_baud.sv - bit-period counter producing a wrap tick
// Ports: clk, reset (sync, active-high), enable (count while high, held at 0
// while low), tick (high on the cycle the counter wraps).
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parametrised parallel-in/serial-out frame transmitter
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready word
// handshake; tx_out registered idle-high serial line; busy high for the whole
// frame; frame_done one-cycle pulse on the last stop-bit cycle.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int FRAME_L = frame_len(CLKS_PER_BIT, DATA_W, PARITY, STOP_BITS);
    localparam int BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int RW      = $clog2(FRAME_L + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
        $error("serial_frame_tx: DATA_W must be 1..16");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("serial_frame_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("serial_frame_tx: CLKS_PER_BIT must be >= 1");
    end

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W:0]   shreg_ext;
    logic              next_bit;
    logic              par_bit;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic [RW-1:0]     remain;
    logic              tick;

    assign in_ready = (state == ST_IDLE);

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .enable(state != ST_IDLE),
        .tick  (tick)
    );

    // Next bit to put on the line and the register after removing it; the
    // vacated position is refilled with 1 so an emptied register reads all-ones.
    always_comb begin
        if (MSB_FIRST != 0) begin
            next_bit   = shreg[DATA_W-1];
            shreg_ext  = {shreg, 1'b1};
            shreg_next = shreg_ext[DATA_W-1:0];
        end else begin
            next_bit   = shreg[0];
            shreg_ext  = {1'b1, shreg};
            shreg_next = shreg_ext[DATA_W:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            remain     <= '0;
        end else begin
            // remain counts down the cycles left in the frame so frame_done can
            // be registered one cycle ahead of the final stop-bit cycle, which
            // the baud tick alone cannot announce early when CLKS_PER_BIT is 1.
            frame_done <= (remain == RW'(1));
            if (remain != '0) begin
                remain <= remain - RW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_START;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        shreg    <= in_data;
                        par_bit  <= (PARITY == PAR_ODD) ? ~^in_data : ^in_data;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        remain   <= RW'(FRAME_L - 1);
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state  <= ST_DATA;
                        tx_out <= next_bit;
                        shreg  <= shreg_next;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != PAR_NONE) begin
                                state  <= ST_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx_out  <= next_bit;
                            shreg   <= shreg_next;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state  <= ST_STOP;
                        tx_out <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parametrised parallel-in/serial-out frame transmitter; successor to the fixed 10-bit shift register.
- Accepts one DATA_W-bit word per valid/ready handshake and builds a frame: start bit, data bits, optional parity, STOP_BITS stop bits.
- Holds each bit for CLKS_PER_BIT clocks and drives an idle-high serial line.
- Sits between the character source and the serial line driver; replaces the external bit-count/load control.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 4, clk cycles per serial bit (>=1).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits (1 or 2).
- MSB_FIRST, 0, data bit order: 0 LSB first, 1 MSB first.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  word to transmit; sampled only on handshake.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word; equals (state==IDLE).
- tx_out  out  1  registered serial line; idle high.
- busy  out  1  registered; high from the cycle after acceptance through the last stop-bit cycle.
- frame_done  out  1  registered one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset: all of the following apply on the next clk edge while reset is high.
  - state=IDLE, tx_out=1, busy=0, frame_done=0.
  - Shift register, bit counter and baud counter cleared; in_ready=1 after reset releases.
- Reset mid-frame aborts the frame. tx_out returns high on the next edge and no frame_done is produced. The aborted word is lost.
- Handshake: a word is accepted when in_valid && in_ready on a rising edge.
  - in_data is latched into an internal shift register and parity is computed from it.
  - in_valid while busy is ignored. The source must hold it until in_ready is high.
- States:
  - IDLE: tx_out=1. On accept, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles. The first START cycle is the cycle after accept (latency 1).
  - DATA: DATA_W bits, each for CLKS_PER_BIT cycles.
    - MSB_FIRST=0 sends in_data[0] first; MSB_FIRST=1 sends in_data[DATA_W-1] first.
    - Shift register is emptied with 1s.
  - PARITY: entered only if PARITY!=0; lasts CLKS_PER_BIT cycles.
    - Even mode: bit = XOR of data bits.
    - Odd mode: bit = inverted XOR of data bits.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, frame_done=1 and next state is IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - State and bit advances occur only on wrap.
  - Counter width is max(1,$clog2(CLKS_PER_BIT)).
  - CLKS_PER_BIT=1 gives one bit per clock.
- Frame length L = CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back words (in_valid held high): frame start period is L+1.
  - The single IDLE cycle between frames keeps tx_out=1.
  - in_ready pulses high for exactly that cycle.
- tx_out is always driven from a flop, so there are no combinational glitches on the line.
- Illegal parameters (PARITY>2, STOP_BITS not 1 or 2, DATA_W<1) fail elaboration.

Decomposition:
- Package serial_pkg:
  - Typedef for the state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - A function returning frame length from the parameters.
- One sub-module, baud_tick_counter:
  - Parameter CLKS_PER_BIT; inputs clk, reset, enable.
  - Output tick, high on the wrap cycle.
  - Reused by the planned receiver.

Test Plan:
- Reset, then idle for 20 cycles -> tx_out=1, busy=0, in_ready=1, frame_done never asserted.
- Defaults with PARITY=1, in_data=8'hA5 accepted at cycle 0:
  - tx_out from cycle 1, each level for 4 cycles: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
  - frame_done at cycle 44; in_ready high again at cycle 45.
- PARITY=2, MSB_FIRST=1, in_data=8'h07 -> data bits 0,0,0,0,0,1,1,1; parity bit 0. PARITY=1 with the same data -> parity bit 1.
- Back-to-back: in_valid held with 8'h55 then 8'hC3, PARITY=0, STOP_BITS=2:
  - Frame length 44.
  - Second start bit begins 45 cycles after the first.
  - Exactly one idle-high cycle between frames.
- Reset asserted at cycle 15 of a frame -> tx_out=1 at cycle 16, state IDLE, no frame_done, next accepted word transmits correctly.
- in_data changed and in_valid toggled while busy -> transmitted bits unchanged, no extra frame.
- CLKS_PER_BIT=1, DATA_W=5, PARITY=0, in_data=5'b10110 -> tx_out 0,0,1,1,0,1,1 on consecutive cycles; frame_done on the stop cycle.
